// File: rtl/avalon_stream_reader_if.sv
// Avalon-MM read master port plus valid/ready stream output of the stream reader.
interface avalon_stream_reader_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 26
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;
    logic                m_valid;
    logic                m_ready;
    logic [DATA_W-1:0]   m_data;

    modport master (
        output avm_address, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output m_valid, m_data,
        input  m_ready
    );

    modport slave (
        input  avm_address, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  m_valid, m_data,
        output m_ready
    );
endinterface

// File: rtl/avalon_stream_reader.sv
// Pipelined Avalon-MM read master: fetches a runtime base/length block of words and
// streams them in order through a credit-checked FIFO, with abort and done pulse.
module avalon_stream_reader #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned ADDR_W      = 26,
    parameter int unsigned LEN_W       = 20,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned MAX_PENDING = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    avalon_stream_reader_if.master bus
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = OCC_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ABORT} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              rd_q, rd_d, mvalid_q, mvalid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issued_q, issued_d, delivered_q, delivered_d;
    logic [OCC_W-1:0]  pending_q, pending_d, occ_q, occ_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic active, take_start, take_abort, hold, accept, ret_ok, push, pop;

    assign active     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign take_start = (state_q == S_IDLE) && start;
    assign take_abort = active && abort;
    assign hold       = rd_q && bus.avm_waitrequest;
    assign accept     = rd_q && !bus.avm_waitrequest;
    // Returns with nothing outstanding are leftovers from before a reset and are dropped.
    assign ret_ok     = bus.avm_readdatavalid && (pending_q != '0);
    assign push       = ret_ok && active && !take_abort;
    assign pop        = mvalid_q && bus.m_ready;

    // Counters, address and FIFO pointers.
    always_comb begin
        issued_d    = issued_q + CNT_W'(accept);
        pending_d   = pending_q + OCC_W'(accept) - OCC_W'(ret_ok);
        delivered_d = delivered_q + CNT_W'(pop);
        len_d       = len_q;
        addr_d      = accept ? addr_q + ADDR_W'(BYTES) : addr_q;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        occ_d       = occ_q + OCC_W'(push) - OCC_W'(pop);
        if (take_start) begin
            issued_d    = '0;
            delivered_d = '0;
            len_d       = length;
            addr_d      = base_addr & ALIGN_MASK;
        end
        if (take_abort) begin
            rd_ptr_d = wr_ptr_q;
            occ_d    = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && (length != '0)) state_d = S_ISSUE;
            S_ISSUE: begin
                if (abort) state_d = S_ABORT;
                else if (issued_d == CNT_W'(len_q)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort) state_d = S_ABORT;
                else if (delivered_d == CNT_W'(len_q)) state_d = S_IDLE;
            end
            S_ABORT: if ((pending_d == '0) && !hold) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs; a stalled request is never retracted, even on abort.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (take_start && (length == '0)) || ((state_q == S_DRAIN) && (state_d == S_IDLE));
        mvalid_d = (occ_d != '0);
        rd_d     = 1'b0;
        if (hold) begin
            rd_d = 1'b1;
        end else if (state_d == S_ISSUE) begin
            rd_d = (issued_d < CNT_W'(len_d))
                && (pending_d < OCC_W'(MAX_PENDING))
                && (({1'b0, pending_d} + {1'b0, occ_d}) < SUM_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            mvalid_q    <= 1'b0;
            addr_q      <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            pending_q   <= '0;
            occ_q       <= '0;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_q        <= rd_d;
            mvalid_q    <= mvalid_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            pending_q   <= pending_d;
            occ_q       <= occ_d;
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.avm_readdata;
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (occ_q == OCC_W'(FIFO_DEPTH))));

    assign busy               = busy_q;
    assign done               = done_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = rd_q;
    assign bus.avm_byteenable = '1;
    assign bus.m_valid        = mvalid_q;
    assign bus.m_data         = mem[rd_ptr_q];
endmodule

// File: tb/tb_avalon_stream_reader.sv
// Randomised bench for avalon_stream_reader: address-hashed SDRAM model with random
// stall/latency, random consumer, and an expected-word list built from base/length.
module tb_avalon_stream_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic [25:0] base_addr = '0;
    logic [19:0] length = '0;
    logic        busy, done;

    avalon_stream_reader_if #(.DATA_W(128), .ADDR_W(26)) bus ();

    avalon_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, accepts = 0, outstanding = 0, fifo_occ = 0, stale = 0, max_occ = 0;
    int done_cnt = 0, read_cycles = 0, last_due = 0;
    int stall_mode = 0, ready_mode = 0, lat_min = 1, lat_max = 1;
    bit aborting = 0, prev_hold = 0;
    logic [25:0]  prev_addr = '0, exp_addr = '0;
    int           due_q[$];
    logic [25:0]  addr_q[$];
    logic [127:0] got_q[$], exp_q[$];

    function automatic logic [127:0] mem_word(input logic [25:0] a);
        return {6'd0, a, 6'd1, a, 6'd2, a, 6'd3, a} ^ {4{32'h5A3C_9617}};
    endfunction

    // Slave memory, protocol monitor and consumer, all acting on the falling edge.
    always @(negedge clk) begin : mon
        logic wreq;
        int   due;
        logic [25:0] a;
        cyc++;
        if (reset && prev_hold) begin
            n_cmp++;
            if (bus.avm_read !== 1'b1 || bus.avm_address !== prev_addr) begin
                n_fail++;
                $display("FAIL stall_hold: read=%b addr=%h, required read=1 addr=%h", bus.avm_read, bus.avm_address, prev_addr);
            end
        end
        if (bus.avm_read === 1'b1) read_cycles++;
        wreq = (stall_mode != 0 && reset) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.avm_waitrequest = wreq;
        prev_hold = reset && (bus.avm_read === 1'b1) && wreq;
        prev_addr = bus.avm_address;
        if (reset && bus.avm_read === 1'b1 && !wreq) begin
            n_cmp++;
            if (bus.avm_address !== exp_addr) begin
                n_fail++;
                $display("FAIL read_addr: got %h, required %h", bus.avm_address, exp_addr);
            end
            exp_addr = exp_addr + 26'h10;
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            due_q.push_back(due);
            addr_q.push_back(bus.avm_address);
            accepts++;
            outstanding++;
        end
        bus.avm_readdatavalid = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            a = addr_q.pop_front();
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = mem_word(a);
            if (stale > 0) stale--;
            else begin
                outstanding--;
                if (!aborting) fifo_occ++;
            end
        end
        if (aborting) fifo_occ = 0;
        case (ready_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset && bus.m_valid === 1'b1 && bus.m_ready) begin
            got_q.push_back(bus.m_data);
            fifo_occ--;
        end
        if (reset && done === 1'b1) done_cnt++;
        if (!reset) begin
            stale += outstanding;
            outstanding = 0;
            fifo_occ = 0;
        end
        if (outstanding + fifo_occ > max_occ) max_occ = outstanding + fifo_occ;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_xfer(input logic [25:0] b, input int n);
        logic [25:0] a0;
        exp_q.delete();
        got_q.delete();
        done_cnt = 0;
        aborting = 0;
        a0 = b & ~26'hF;
        exp_addr = a0;
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(a0 + 26'(i * 16)));
        base_addr = b;
        length = 20'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
        n_cmp++; if (bus.avm_read !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b, required 0", bus.avm_read); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid: got %b, required 0", bus.m_valid); end
        n_cmp++; if (bus.avm_address !== 26'h0) begin n_fail++; $display("FAIL rst_addr: got %h, required 0", bus.avm_address); end
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.avm_byteenable !== 16'hFFFF) begin n_fail++; $display("FAIL byteenable: got %h, required ffff", bus.avm_byteenable); end
    endtask

    task automatic test_basic();
        bit to;
        stall_mode = 0; ready_mode = 1; lat_min = 1; lat_max = 1;
        start_xfer(26'h31F00, 4);
        wait_done(100, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL basic_done: no done within 100 cycles, required one"); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b with done, required 0", busy); end
        n_cmp++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d words, required 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: done got %b a cycle later, required 0", done); end
        repeat (3) tick();
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d, required 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        bit to;
        int stable = 0, last = -1;
        stall_mode = 0; ready_mode = 0; lat_min = 1; lat_max = 3; max_occ = 0;
        start_xfer(26'h0040000, 40);
        for (int i = 0; i < 300 && stable < 12; i++) begin
            tick();
            if (accepts == last) stable++;
            else begin stable = 0; last = accepts; end
        end
        n_cmp++; if (outstanding + fifo_occ != 16) begin n_fail++; $display("FAIL bp_credit: pending+fifo got %0d, required 16", outstanding + fifo_occ); end
        n_cmp++; if (max_occ > 16) begin n_fail++; $display("FAIL bp_overflow: peak occupancy got %0d, required <=16", max_occ); end
        n_cmp++; if (bus.avm_read !== 1'b0) begin n_fail++; $display("FAIL bp_read: got %b while full, required 0", bus.avm_read); end
        ready_mode = 1;
        wait_done(400, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL bp_done: no done within 400 cycles, required one"); end
        n_cmp++; if (got_q.size() != 40) begin n_fail++; $display("FAIL bp_count: got %0d words, required 40", got_q.size()); end
        for (int i = 0; i < 40 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_stall();
        bit to;
        logic [25:0] b;
        stall_mode = 1; ready_mode = 2; lat_min = 1; lat_max = 6;
        for (int it = 0; it < 3; it++) begin
            b = (it == 0) ? 26'h3FFFFC7 : 26'($urandom);
            start_xfer(b, 25);
            wait_done(800, to);
            n_cmp++; if (to) begin n_fail++; $display("FAIL rnd_done%0d: no done within 800 cycles, required one", it); end
            n_cmp++; if (got_q.size() != 25) begin n_fail++; $display("FAIL rnd_count%0d: got %0d words, required 25", it, got_q.size()); end
            for (int i = 0; i < 25 && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_word%0d_%0d: got %h, required %h", it, i, got_q[i], exp_q[i]); end
            end
            tick();
        end
        stall_mode = 0;
    endtask

    task automatic test_len_zero_and_busy_start();
        bit to;
        int r0;
        ready_mode = 1; lat_min = 1; lat_max = 2;
        r0 = read_cycles;
        done_cnt = 0;
        base_addr = 26'h1000; length = '0; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b one cycle after start, required 1", done); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL len0_pulse: got %b two cycles after start, required 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b, required 0", busy); end
        repeat (3) tick();
        n_cmp++; if (read_cycles != r0) begin n_fail++; $display("FAIL len0_reads: got %0d read cycles, required %0d", read_cycles, r0); end
        ready_mode = 0;
        start_xfer(26'h0200, 6);
        repeat (3) tick();
        base_addr = 26'h3000; length = 20'd2; start = 1'b1;
        tick();
        start = 1'b0;
        ready_mode = 1;
        wait_done(200, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL busy_start_done: no done within 200 cycles, required one"); end
        n_cmp++; if (got_q.size() != 6) begin n_fail++; $display("FAIL busy_start_count: got %0d words, required 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_start_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        repeat (3) tick();
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done_cnt: got %0d, required 1", done_cnt); end
    endtask

    task automatic test_abort();
        int acc0, snap, mv_bad = 0, out_at_idle = -1;
        stall_mode = 0; ready_mode = 0; lat_min = 3; lat_max = 3;
        acc0 = accepts;
        start_xfer(26'h0500, 20);
        for (int i = 0; i < 50 && accepts - acc0 < 5; i++) tick();
        abort = 1'b1;
        aborting = 1'b1;
        tick();
        abort = 1'b0;
        snap = accepts;
        for (int i = 0; i < 20; i++) begin
            if (bus.m_valid !== 1'b0) mv_bad++;
            if (out_at_idle < 0 && busy === 1'b0) out_at_idle = outstanding;
            tick();
        end
        n_cmp++; if (accepts != snap) begin n_fail++; $display("FAIL abort_reads: got %0d accepts, required %0d", accepts, snap); end
        n_cmp++; if (mv_bad != 0) begin n_fail++; $display("FAIL abort_mvalid: m_valid high %0d cycles, required 0", mv_bad); end
        n_cmp++; if (out_at_idle != 0) begin n_fail++; $display("FAIL abort_idle: pending at idle got %0d, required 0", out_at_idle); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy); end
        n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses, required 0", done_cnt); end
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL abort_words: got %0d words, required 0", got_q.size()); end
        aborting = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        bit to;
        int n_before;
        stall_mode = 0; ready_mode = 1; lat_min = 4; lat_max = 6;
        start_xfer(26'h12340, 30);
        repeat (8) tick();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        n_cmp++; if (bus.avm_read !== 1'b0) begin n_fail++; $display("FAIL midrst_read: got %b, required 0", bus.avm_read); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_mvalid: got %b, required 0", bus.m_valid); end
        n_cmp++; if (bus.avm_address !== 26'h0) begin n_fail++; $display("FAIL midrst_addr: got %h, required 0", bus.avm_address); end
        reset = 1'b1;
        n_before = got_q.size();
        for (int i = 0; i < 40 && due_q.size() > 0; i++) tick();
        tick();
        n_cmp++; if (got_q.size() != n_before) begin n_fail++; $display("FAIL stale_words: got %0d words, required %0d", got_q.size(), n_before); end
        n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL stale_mvalid: got %b, required 0", bus.m_valid); end
        start_xfer(26'h0, 2);
        wait_done(100, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL post_rst_done: no done within 100 cycles, required one"); end
        n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL post_rst_count: got %0d words, required 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL post_rst_word%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random_stall();
        test_len_zero_and_busy_start();
        test_abort();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
